tensorcore_seq: RTL and testbench

Parametrised tile sequencer for the tensor core: it orders the C load, the A/B operand loads, systolic compute, optional INT4 accumulation and write-back, and repeats the A/B/compute part over a configurable number of K tiles. It sits between the memory/AXI request port and the systolic array. It drives a valid/ready request handshake toward memory and enable strobes toward the array, and it honours a stall from the floating-point pipeline.

---
 rtl/params.sv | 29 ++
 rtl/tc_mem_req.sv | 39 +++
 rtl/tensorcore_seq.sv | 181 ++++++++++++++++++
 tb/tb_tensorcore_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/params.sv
// Shared types for the tensor-core tile sequencer and its memory request helper.
package params;

   typedef enum logic [2:0] {
      StIdle,
      StLoadC,
      StLoadA,
      StLoadB,
      StSystolic,
      StAccum,
      StWriteBack,
      StDone
   } seq_state_e;

   typedef enum logic [1:0] {
      DtInt8,
      DtFp16,
      DtFp32,
      DtInt4
   } dtype_e;

   typedef enum logic [1:0] {
      SelC,
      SelA,
      SelB,
      SelD
   } mem_sel_e;

endpackage

// File: rtl/tc_mem_req.sv
// Single outstanding memory request: valid/ready handshake plus completion qualification.
module tc_mem_req (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   input  logic ready,
   input  logic done_in,
   output logic valid,
   output logic complete
);

   logic valid_q;
   logic accepted_q;
   logic accept;

   assign accept   = valid_q & ready;
   // A done pulse only belongs to this request once it has been accepted.
   assign complete = done_in & (accepted_q | accept);
   assign valid    = valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         accepted_q <= 1'b0;
      end else begin
         if (kick) begin
            valid_q <= 1'b1;
         end else if (accept) begin
            valid_q <= 1'b0;
         end
         if (kick || complete) begin
            accepted_q <= 1'b0;
         end else if (accept) begin
            accepted_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tensorcore_seq.sv
// Tile sequencer: C load, K-tile loop of A/B load + systolic compute, optional INT4
// accumulate, then D write-back.
module tensorcore_seq
   import params::*;
#(
   parameter int unsigned L          = 8,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned KT_W       = 8,
   parameter int unsigned ACC_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [KT_W-1:0]   cfg_ktiles,
   input  logic [1:0]        cfg_dtype,
   input  logic [CNT_W-1:0]  cfg_sys_cycles,
   output logic              mem_req_valid,
   output logic [1:0]        mem_req_sel,
   output logic [KT_W-1:0]   mem_req_tile,
   input  logic              mem_req_ready,
   input  logic              mem_done,
   input  logic              sys_stall,
   output logic              sys_en,
   output logic              acc_en,
   output logic              busy,
   output logic              done,
   output logic [2:0]        state_o
);

   localparam int unsigned AccW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;

   if (L < 1) begin : gen_l_check
      $error("L must be at least 1");
   end
   if (ACC_CYCLES < 1) begin : gen_acc_check
      $error("ACC_CYCLES must be at least 1");
   end

   seq_state_e        state_q, state_d;
   dtype_e            dtype_q;
   logic [KT_W-1:0]   ktiles_q;
   logic [CNT_W-1:0]  sys_cycles_q;
   logic [KT_W-1:0]   tile_idx_q, tile_idx_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AccW-1:0]   acc_cnt_q, acc_cnt_d;
   mem_sel_e          sel_q, sel_d;
   logic [KT_W-1:0]   tile_q, tile_d;
   logic              acc_en_q;
   logic              kick;
   logic              complete;

   tc_mem_req u_mem_req (
      .clk      (clk),
      .rst      (rst),
      .kick     (kick),
      .ready    (mem_req_ready),
      .done_in  (mem_done),
      .valid    (mem_req_valid),
      .complete (complete)
   );

   assign sys_en       = (state_q == StSystolic) && !sys_stall;
   assign busy         = (state_q != StIdle);
   assign done         = (state_q == StDone);
   assign state_o      = state_q;
   assign acc_en       = acc_en_q;
   assign mem_req_sel  = sel_q;
   assign mem_req_tile = tile_q;

   always_comb begin
      state_d    = state_q;
      tile_idx_d = tile_idx_q;
      cnt_d      = cnt_q;
      acc_cnt_d  = acc_cnt_q;
      sel_d      = sel_q;
      tile_d     = tile_q;
      kick       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d    = StLoadC;
               tile_idx_d = '0;
               kick       = 1'b1;
               sel_d      = SelC;
               tile_d     = '0;
            end
         end
         StLoadC: begin
            if (complete) begin
               state_d = StLoadA;
               kick    = 1'b1;
               sel_d   = SelA;
               tile_d  = tile_idx_q;
            end
         end
         StLoadA: begin
            if (complete) begin
               state_d = StLoadB;
               kick    = 1'b1;
               sel_d   = SelB;
               tile_d  = tile_idx_q;
            end
         end
         StLoadB: begin
            if (complete) begin
               state_d = StSystolic;
               cnt_d   = sys_cycles_q - CNT_W'(1);
            end
         end
         StSystolic: begin
            if (sys_en) begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else if (tile_idx_q < ktiles_q - KT_W'(1)) begin
                  state_d    = StLoadA;
                  tile_idx_d = tile_idx_q + KT_W'(1);
                  kick       = 1'b1;
                  sel_d      = SelA;
                  tile_d     = tile_idx_q + KT_W'(1);
               end else if (dtype_q == DtInt4) begin
                  state_d   = StAccum;
                  acc_cnt_d = AccW'(ACC_CYCLES - 1);
               end else begin
                  state_d = StWriteBack;
                  kick    = 1'b1;
                  sel_d   = SelD;
                  tile_d  = '0;
               end
            end
         end
         StAccum: begin
            if (acc_cnt_q == '0) begin
               state_d = StWriteBack;
               kick    = 1'b1;
               sel_d   = SelD;
               tile_d  = '0;
            end else begin
               acc_cnt_d = acc_cnt_q - AccW'(1);
            end
         end
         StWriteBack: begin
            if (complete) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         dtype_q      <= DtInt8;
         ktiles_q     <= KT_W'(1);
         sys_cycles_q <= CNT_W'(1);
         tile_idx_q   <= '0;
         cnt_q        <= '0;
         acc_cnt_q    <= '0;
         sel_q        <= SelC;
         tile_q       <= '0;
         acc_en_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tile_idx_q <= tile_idx_d;
         cnt_q      <= cnt_d;
         acc_cnt_q  <= acc_cnt_d;
         sel_q      <= sel_d;
         tile_q     <= tile_d;
         acc_en_q   <= (state_d == StAccum);
         // Zero counts collapse to one so a job always makes forward progress.
         if (state_q == StIdle && start) begin
            dtype_q      <= dtype_e'(cfg_dtype);
            ktiles_q     <= (cfg_ktiles == '0) ? KT_W'(1) : cfg_ktiles;
            sys_cycles_q <= (cfg_sys_cycles == '0) ? CNT_W'(1) : cfg_sys_cycles;
         end
      end
   end

endmodule

// File: tb/tb_tensorcore_seq.sv
// Directed bench for tensorcore_seq: table of whole jobs against a reactive memory model,
// plus hand sequences for handshake, stall-free corner cases and reset.
module tb_tensorcore_seq;
   import params::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  cfg_ktiles;
   logic [1:0]  cfg_dtype;
   logic [15:0] cfg_sys_cycles;
   logic        mem_req_valid;
   logic [1:0]  mem_req_sel;
   logic [7:0]  mem_req_tile;
   logic        mem_req_ready;
   logic        mem_done;
   logic        sys_stall;
   logic        sys_en;
   logic        acc_en;
   logic        busy;
   logic        done;
   logic [2:0]  state_o;

   int checks = 0;
   int errors = 0;

   tensorcore_seq #(
      .L          (8),
      .CNT_W      (16),
      .KT_W       (8),
      .ACC_CYCLES (1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .cfg_ktiles     (cfg_ktiles),
      .cfg_dtype      (cfg_dtype),
      .cfg_sys_cycles (cfg_sys_cycles),
      .mem_req_valid  (mem_req_valid),
      .mem_req_sel    (mem_req_sel),
      .mem_req_tile   (mem_req_tile),
      .mem_req_ready  (mem_req_ready),
      .mem_done       (mem_done),
      .sys_stall      (sys_stall),
      .sys_en         (sys_en),
      .acc_en         (acc_en),
      .busy           (busy),
      .done           (done),
      .state_o        (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ktiles;
      int dtype;
      int sys_cycles;
      int stall_at;
      int stall_len;
      int ready_lat;
      int done_lat;
      int exp_sys_en;
      int exp_sys_cyc;
      int exp_acc;
      int exp_nreq;
      int exp_lat;  // 0: latency not checked
   } vec_t;

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] model_sel(input int k);
      logic [31:0] code = '0;
      for (int t = 0; t < k; t++) code = {code[27:0], 2'd1, 2'd2};
      code = {code[29:0], 2'd3};
      return code;
   endfunction

   function automatic logic [31:0] model_tile(input int k);
      logic [31:0] code = '0;
      for (int t = 0; t < k; t++) code = {code[23:0], t[3:0], t[3:0]};
      code = {code[27:0], 4'd0};
      return code;
   endfunction

   function automatic logic [17:0] out_vec();
      return {mem_req_valid, mem_req_sel, mem_req_tile, sys_en, acc_en, busy, done, state_o};
   endfunction

   vec_t        vecs[7];
   int          n, sys_cnt, sys_cyc, acc_cnt, done_cnt, nreq, vcnt, dcnt, stall_rem;
   int          done_at, last_sys, acc_first, d_first, k_eff, vlow;
   bit          dpend;
   logic [31:0] sel_code, tile_code;

   initial begin
      vecs[0] = '{1, 1, 4, 0, 0, 2, 0, 4, 4, 0, 4, 0};
      vecs[1] = '{3, 0, 2, 0, 0, 1, 1, 6, 6, 0, 8, 0};
      vecs[2] = '{1, 3, 3, 0, 0, 0, 2, 3, 3, 1, 4, 0};
      vecs[3] = '{1, 2, 5, 2, 3, 0, 0, 5, 8, 0, 4, 0};
      vecs[4] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 0};
      vecs[5] = '{2, 3, 1, 0, 0, 1, 0, 2, 2, 1, 6, 0};
      vecs[6] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 0, 4, 6};

      rst = 1'b1; start = 1'b0; cfg_ktiles = '0; cfg_dtype = '0; cfg_sys_cycles = '0;
      mem_req_ready = 1'b0; mem_done = 1'b0; sys_stall = 1'b0;
      @(negedge clk);
      cyc();
      chk("reset_outputs", out_vec(), 0);
      rst = 1'b0;

      // Early done, long ready stall, ignored start, reset mid-load, stray done.
      start = 1'b1; cfg_ktiles = 8'd1; cfg_dtype = 2'd1; cfg_sys_cycles = 16'd1;
      cyc();
      start = 1'b0;
      chk("start_to_valid", {mem_req_valid, state_o}, {1'b1, 3'(StLoadC)});
      vlow = 0;
      for (int i = 0; i < 10; i++) begin
         if (!mem_req_valid) vlow++;
         mem_req_ready = 1'b0;
         mem_done = (i == 3);
         start = (i == 5);
         cfg_ktiles = 8'd7;
         cyc();
      end
      mem_done = 1'b0; start = 1'b0;
      chk("valid_held_no_ready", vlow, 0);
      chk("early_done_ignored", state_o, StLoadC);
      chk("start_ignored_sel", {mem_req_valid, mem_req_sel}, {1'b1, 2'd0});
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0;
      chk("valid_drop_after_accept", {mem_req_valid, state_o}, {1'b0, 3'(StLoadC)});
      mem_done = 1'b1;
      cyc();
      chk("late_done_advances", {mem_req_valid, mem_req_sel, state_o},
          {1'b1, 2'd1, 3'(StLoadA)});
      mem_req_ready = 1'b1;
      cyc();
      mem_req_ready = 1'b0; mem_done = 1'b0;
      chk("zero_bubble_load_b", {mem_req_valid, mem_req_sel, state_o},
          {1'b1, 2'd2, 3'(StLoadB)});
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("reset_in_load_b", out_vec(), 0);
      mem_done = 1'b1;
      cyc();
      mem_done = 1'b0;
      cyc();
      chk("stray_done_idle", out_vec(), 0);

      // Whole-job vectors against a reactive memory responder.
      for (int vi = 0; vi < 7; vi++) begin
         n = 0; sys_cnt = 0; sys_cyc = 0; acc_cnt = 0; done_cnt = 0; nreq = 0;
         vcnt = 0; dcnt = 0; dpend = 1'b0; stall_rem = vecs[vi].stall_len;
         done_at = -1; last_sys = -1; acc_first = -1; d_first = -1;
         sel_code = '0; tile_code = '0;
         k_eff = (vecs[vi].ktiles == 0) ? 1 : vecs[vi].ktiles;
         cfg_ktiles = 8'(vecs[vi].ktiles);
         cfg_dtype = 2'(vecs[vi].dtype);
         cfg_sys_cycles = 16'(vecs[vi].sys_cycles);
         start = 1'b1;
         cyc();
         start = 1'b0;
         n = 1;
         while (n < 400 && !(done_at >= 0 && n >= done_at + 2)) begin
            if (sys_en) begin sys_cnt++; last_sys = n; end
            if (state_o == StSystolic) sys_cyc++;
            if (acc_en) begin acc_cnt++; if (acc_first < 0) acc_first = n; end
            if (mem_req_valid && mem_req_sel == 2'd3 && d_first < 0) d_first = n;
            if (done) begin done_cnt++; if (done_at < 0) done_at = n; end
            mem_req_ready = 1'b0;
            mem_done = 1'b0;
            if (dpend) begin
               if (dcnt == 0) begin mem_done = 1'b1; dpend = 1'b0; end
               else dcnt--;
            end
            if (mem_req_valid) begin
               if (vcnt == vecs[vi].ready_lat) begin
                  mem_req_ready = 1'b1;
                  nreq++;
                  sel_code = {sel_code[29:0], mem_req_sel};
                  tile_code = {tile_code[27:0], mem_req_tile[3:0]};
                  vcnt = 0;
                  if (vecs[vi].done_lat == 0) mem_done = 1'b1;
                  else begin dpend = 1'b1; dcnt = vecs[vi].done_lat - 1; end
               end else vcnt++;
            end else vcnt = 0;
            if (state_o == StSystolic && sys_cnt == vecs[vi].stall_at && stall_rem > 0) begin
               sys_stall = 1'b1;
               stall_rem--;
            end else sys_stall = 1'b0;
            cyc();
            n++;
         end
         mem_req_ready = 1'b0; mem_done = 1'b0; sys_stall = 1'b0;
         chk($sformatf("v%0d_finished", vi), done_at >= 0, 1);
         chk($sformatf("v%0d_done_pulses", vi), done_cnt, 1);
         chk($sformatf("v%0d_sys_en", vi), sys_cnt, vecs[vi].exp_sys_en);
         chk($sformatf("v%0d_systolic_cycles", vi), sys_cyc, vecs[vi].exp_sys_cyc);
         chk($sformatf("v%0d_acc_en", vi), acc_cnt, vecs[vi].exp_acc);
         chk($sformatf("v%0d_requests", vi), nreq, vecs[vi].exp_nreq);
         chk($sformatf("v%0d_sel_seq", vi), sel_code, model_sel(k_eff));
         chk($sformatf("v%0d_tile_seq", vi), tile_code, model_tile(k_eff));
         chk($sformatf("v%0d_idle_after", vi), {busy, state_o}, 0);
         if (vecs[vi].exp_lat != 0) chk($sformatf("v%0d_latency", vi), done_at, vecs[vi].exp_lat);
         if (vecs[vi].dtype == 3) begin
            chk($sformatf("v%0d_acc_after_sys", vi), acc_first, last_sys + 1);
            chk($sformatf("v%0d_d_after_acc", vi), d_first, acc_first + 1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
